melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Steps through a fixed internal note table and produces, per note, a half-period divider value and a gate for the square-wave tone generator that drives the buzzer pin. It sits directly upstream of the tone generator. The tone generator toggles its output every DIV+1 clocks while GATE=1 and holds low while GATE=0. All timing is derived from the 16 MHz board clock.

## Interface
- CLK_HZ, 16000000: clock frequency; used only to build the divider table.
- TICK_CLKS, 1000000: clocks per duration tick (16 ticks/s at 16 MHz); must be ≥ 2.
- GAP_CLKS, 16000: silent articulation gap at the end of each note, in clocks; must be < TICK_CLKS.
- SONG_LEN, 16: number of note-table entries.
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  run enable; low stops playback and rewinds to entry 0.
- LOOP  input  1  at end of song, restart from entry 0 instead of stopping.
- DIV  output  15  half-period count minus 1 for the tone generator.
- GATE  output  1  1 = tone sounding, 0 = silent.
- NOTE_STB  output  1  one-cycle pulse when DIV/GATE take a new note.
- DONE  output  1  one-cycle pulse when the end of song is reached with LOOP=0.

## Operation
- Table entry fields:
  - note[3:0]: 0 = rest, 1..12 = C..B.
  - oct[1:0]: octave shift 0..3.
  - dur[3:0]: length in ticks; 0 = end-of-song marker.
- Base half-period table: H[n] = round(CLK_HZ/(2·f_n)) for C4..B4. Examples: C4 = 30578, A4 = 18182.
- DIV = (H[note] >> oct) − 1, 15-bit. DIV is unchanged for rests.
- Default table contents:
  - entry 0: A, oct 0, dur 4.
  - entry 1: rest, dur 2.
  - entry 2: C, oct 1, dur 1 (DIV = 15288).
  - entry 3: end marker.
  - entries 4..15: end markers.
- FSM states: IDLE, LOAD, PLAY, STOPPED.
- IDLE: GATE=0, ptr=0. EN=1 → LOAD.
- LOAD (1 cycle): read entry[ptr].
  - dur=0 with LOOP=1: ptr←0, remain in LOAD.
  - dur=0 with LOOP=0: pulse DONE, → STOPPED.
  - otherwise: DIV←computed (held for rests), GATE←(note≠0), pulse NOTE_STB, ticks_left←dur, prescaler←0, → PLAY.
- PLAY: the prescaler counts 0..TICK_CLKS−1; at TICK_CLKS−1 it wraps and ticks_left decrements.
  - When ticks_left=1 and the prescaler reaches TICK_CLKS−1: ptr←ptr+1, → LOAD.
  - ptr = SONG_LEN−1 with no marker: next is treated as an end marker.
- Articulation gap: GATE forced to 0 when ticks_left=1 and prescaler ≥ TICK_CLKS−GAP_CLKS. DIV is unchanged.
- STOPPED: GATE=0, DIV held. Stays until EN=0.
- EN=0 in any state: → IDLE on the next edge. GATE=0 and ptr=0 that same edge. No NOTE_STB or DONE is issued.
- LOOP is sampled only in LOAD at a marker.

## Timing
- Reset values: state=IDLE, ptr=0, DIV=0, GATE=0, NOTE_STB=0, DONE=0. All outputs are registered.
- EN rising in IDLE → LOAD at edge 1 → NOTE_STB high in the cycle after edge 2. DIV and GATE are valid in the same cycle as NOTE_STB.
- NOTE_STB to next NOTE_STB (or DONE) = dur·TICK_CLKS + 1 clocks. The LOAD cycle adds 1 clock per note; GATE holds its previous value during LOAD.
- GATE is high for dur·TICK_CLKS − GAP_CLKS clocks per sounding note, starting with the NOTE_STB cycle.
- Loop restart: a marker in LOAD costs 1 extra clock, so marker → NOTE_STB of entry 0 is 2 clocks.
- Reset asserted mid-note: all outputs return to reset values immediately (asynchronous). Playback restarts from entry 0 after release if EN=1.
- DONE and NOTE_STB are never high in the same cycle.

## Test plan
- Reset with EN=0: all outputs 0. Hold 100 clocks: GATE stays 0, no strobes.
- TICK_CLKS=10, GAP_CLKS=2, EN=1, LOOP=0, default table:
  - NOTE_STB at t0 with DIV=18181 and GATE high for 38 clocks.
  - Rest: NOTE_STB at t0+41, GATE=0, DIV still 18181.
  - NOTE_STB at t0+62 with DIV=15288 and GATE high for 8 clocks.
  - DONE at t0+73; STOPPED thereafter.
- Same as above with LOOP=1: entry 0 NOTE_STB recurs at t0+74 with DIV=18181. No DONE ever.
- EN dropped at t0+20 (mid-note): GATE=0 and IDLE on the next edge. Re-raising EN restarts at entry 0 (DIV=18181).
- RST_N pulsed low at t0+45: outputs zero asynchronously. After release with EN=1, the first NOTE_STB comes 2 clocks later with DIV=18181.
- DIV arithmetic check across oct 0..3 for A (override table): DIV = 18181, 9090, 4544, 2271.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// Control and note-output bundle between a melody_sequencer and its user.
//   en, loop        : run enable / loop-at-end request (master -> sequencer)
//   div[14:0]       : tone generator half-period count minus 1
//   gate            : 1 = tone sounding
//   note_stb, done  : one-cycle pulses for a new note / end of song
interface melody_sequencer_if;
    logic        en;
    logic        loop;
    logic [14:0] div;
    logic        gate;
    logic        note_stb;
    logic        done;

    modport master (output en, loop, input div, gate, note_stb, done);
    modport slave  (input en, loop, output div, gate, note_stb, done);
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a constant note table and emits, per note, a half-period
// divider and a gate for a downstream square-wave tone generator.
//   clk, rst_n : system clock, asynchronous active-low reset
//   seq_if     : slave side of melody_sequencer_if (en/loop in, div/gate/
//                note_stb/done out, all outputs registered)
// Table entry packing (10 bits, entry i at bits [i*10 +: 10]):
//   {note[3:0], oct[1:0], dur[3:0]}; note 0 = rest, 1..12 = C..B,
//   dur 0 = end-of-song marker.
module melody_sequencer #(
    parameter int unsigned CLK_HZ    = 16000000,
    parameter int unsigned TICK_CLKS = 1000000,
    parameter int unsigned GAP_CLKS  = 16000,
    parameter int unsigned SONG_LEN  = 16,
    parameter logic [SONG_LEN*10-1:0] SONG_TABLE = (SONG_LEN*10)'({
        {4'd1,  2'd1, 4'd1},    // entry 2: C, one octave up, 1 tick
        {4'd0,  2'd0, 4'd2},    // entry 1: rest, 2 ticks
        {4'd10, 2'd0, 4'd4}     // entry 0: A, 4 ticks
    })
) (
    input  logic                clk,
    input  logic                rst_n,
    melody_sequencer_if.slave   seq_if
);

    localparam int unsigned ENTRY_W = 10;
    localparam int unsigned DIV_W   = 15;
    localparam int unsigned PRESC_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam int unsigned PTR_W   = $clog2(SONG_LEN + 1);

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] oct;
        logic [3:0] dur;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_STOPPED
    } state_t;

    // Rounded CLK_HZ / (2 * f); f given in millihertz for the 4th octave.
    function automatic logic [15:0] half_period(input int unsigned f_mhz);
        longint unsigned f;
        longint unsigned num;
        f   = 64'(f_mhz);
        num = 64'(CLK_HZ) * 64'd1000 + f;
        return 16'(num / (64'd2 * f));
    endfunction

    // Indexed directly by note; slot 0 (rest) and 13..15 are unused.
    localparam logic [15:0] H_TAB [16] = '{
        16'd0,
        half_period(261626), half_period(277183), half_period(293665),
        half_period(311127), half_period(329628), half_period(349228),
        half_period(369994), half_period(391995), half_period(415305),
        half_period(440000), half_period(466164), half_period(493883),
        16'd0, 16'd0, 16'd0
    };

    state_t               state_q,  state_d;
    logic [PTR_W-1:0]     ptr_q,    ptr_d;
    logic [DIV_W-1:0]     div_q,    div_d;
    logic                 gate_q,   gate_d;
    logic                 stb_q,    stb_d;
    logic                 done_q,   done_d;
    logic [PRESC_W-1:0]   presc_q,  presc_d;
    logic [3:0]           ticks_q,  ticks_d;

    entry_t               entry;
    logic                 is_marker;
    logic                 note_ok;
    logic                 tick_end;
    logic                 gap_now;
    logic [DIV_W-1:0]     div_new;

    // Table read for the current pointer; past the last entry reads as a marker.
    always_comb begin
        entry = '0;
        for (int i = 0; i < SONG_LEN; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                entry = SONG_TABLE[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    assign is_marker = (ptr_q >= PTR_W'(SONG_LEN)) || (entry.dur == 4'd0);
    // Note codes 13..15 have no pitch and play as rests.
    assign note_ok   = (entry.note != 4'd0) && (entry.note <= 4'd12);
    assign div_new   = DIV_W'((H_TAB[entry.note] >> entry.oct) - 16'd1);
    assign tick_end  = (presc_q == PRESC_W'(TICK_CLKS - 1));
    // Registered gate: decide one clock early so it is already low on the
    // first cycle of the articulation gap.
    assign gap_now   = (GAP_CLKS != 0) && (ticks_q == 4'd1) &&
                       (presc_q >= PRESC_W'(TICK_CLKS - GAP_CLKS - 1));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            div_q   <= '0;
            gate_q  <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            div_q   <= div_d;
            gate_q  <= gate_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            ticks_q <= ticks_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        div_d   = div_q;
        gate_d  = gate_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;
        presc_d = presc_q;
        ticks_d = ticks_q;

        if (!seq_if.en) begin
            // Stop and rewind from any state; DIV keeps its last value.
            state_d = S_IDLE;
            ptr_d   = '0;
            gate_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ptr_d   = '0;
                    gate_d  = 1'b0;
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (is_marker) begin
                        if (seq_if.loop) begin
                            ptr_d = '0;
                        end else begin
                            done_d  = 1'b1;
                            gate_d  = 1'b0;
                            state_d = S_STOPPED;
                        end
                    end else begin
                        if (note_ok) begin
                            div_d = div_new;
                        end
                        gate_d  = note_ok;
                        stb_d   = 1'b1;
                        ticks_d = entry.dur;
                        presc_d = '0;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (gap_now) begin
                        gate_d = 1'b0;
                    end
                    if (tick_end) begin
                        presc_d = '0;
                        ticks_d = ticks_q - 4'd1;
                        if (ticks_q == 4'd1) begin
                            ptr_d   = ptr_q + PTR_W'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                S_STOPPED: begin
                    gate_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign seq_if.div      = div_q;
    assign seq_if.gate     = gate_q;
    assign seq_if.note_stb = stb_q;
    assign seq_if.done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

    localparam logic [14:0] DIV_A  = 15'd18181;
    localparam logic [14:0] DIV_C5 = 15'd15288;

    // A in octaves 0..3, one tick each, then end marker.
    localparam logic [159:0] OCT_TABLE = 160'({
        {4'd10, 2'd3, 4'd1},
        {4'd10, 2'd2, 4'd1},
        {4'd10, 2'd1, 4'd1},
        {4'd10, 2'd0, 4'd1}
    });

    typedef struct {
        int          cyc;
        logic        is_done;
        logic [14:0] div;
        logic        gate;
        int          plen;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   glen  = 0;
    logic sel   = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    melody_sequencer_if if1 ();
    melody_sequencer_if if2 ();

    melody_sequencer #(
        .TICK_CLKS (10),
        .GAP_CLKS  (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (if1)
    );

    melody_sequencer #(
        .TICK_CLKS  (10),
        .GAP_CLKS   (2),
        .SONG_TABLE (OCT_TABLE)
    ) dut_oct (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (if2)
    );

    // Scoreboard monitor: every strobe pops one expected event.
    always @(negedge clk) begin
        logic [14:0] d;
        logic g, s, dn;
        exp_t e;
        d  = sel ? if2.div      : if1.div;
        g  = sel ? if2.gate     : if1.gate;
        s  = sel ? if2.note_stb : if1.note_stb;
        dn = sel ? if2.done     : if1.done;
        if (s === 1'b1 && dn === 1'b1) begin
            total++; bad++;
            $display("FAIL strobe_overlap: note_stb and done both high at cycle %0d", cyc);
        end
        if (s === 1'b1 || dn === 1'b1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_event: stb=%0b done=%0b at cycle %0d", s, dn, cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL event_time: got cycle %0d want %0d", cyc, e.cyc);
                end
                total++;
                if (dn !== e.is_done) begin
                    bad++;
                    $display("FAIL event_kind: got done=%0b want %0b (cycle %0d)", dn, e.is_done, cyc);
                end
                total++;
                if (d !== e.div) begin
                    bad++;
                    $display("FAIL event_div: got %0d want %0d (cycle %0d)", d, e.div, cyc);
                end
                total++;
                if (g !== e.gate) begin
                    bad++;
                    $display("FAIL event_gate: got %0b want %0b (cycle %0d)", g, e.gate, cyc);
                end
                if (e.plen >= 0) begin
                    total++;
                    if (glen !== e.plen) begin
                        bad++;
                        $display("FAIL gate_len: got %0d want %0d (cycle %0d)", glen, e.plen, cyc);
                    end
                end
            end
            glen = (g === 1'b1) ? 1 : 0;
        end else if (g === 1'b1) begin
            glen++;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input logic dn, input logic [14:0] d,
                           input logic g, input int plen);
        exp_t e;
        e.cyc = c; e.is_done = dn; e.div = d; e.gate = g; e.plen = plen;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        int gh;
        if1.en = 1'b0; if1.loop = 1'b0;
        if2.en = 1'b0; if2.loop = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (if1.div !== 15'd0) begin bad++; $display("FAIL reset_div: got %0d want 0", if1.div); end
        total++;
        if (if1.gate !== 1'b0) begin bad++; $display("FAIL reset_gate: got %b want 0", if1.gate); end
        total++;
        if (if1.note_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", if1.note_stb); end
        total++;
        if (if1.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", if1.done); end
        @(negedge clk);
        rst_n = 1'b1;
        gh = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if1.gate !== 1'b0) gh++;
        end
        total++;
        if (gh !== 0) begin bad++; $display("FAIL idle_gate: got %0d gate-high cycles want 0", gh); end
    endtask

    task automatic test_play_once();
        int base;
        if1.loop = 1'b0;
        @(negedge clk);
        base = cyc;
        push_ev(base + 2,  1'b0, DIV_A,  1'b1, -1);
        push_ev(base + 43, 1'b0, DIV_A,  1'b0, 38);
        push_ev(base + 64, 1'b0, DIV_C5, 1'b1, 0);
        push_ev(base + 75, 1'b1, DIV_C5, 1'b0, 8);
        if1.en = 1'b1;
        wait_until(base + 90);
        total++;
        if (if1.gate !== 1'b0) begin bad++; $display("FAIL stopped_gate: got %b want 0", if1.gate); end
        total++;
        if (if1.div !== DIV_C5) begin bad++; $display("FAIL stopped_div: got %0d want %0d", if1.div, DIV_C5); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL once_missing: got %0d pending want 0", sb.size()); sb.delete(); end
        if1.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loop();
        int base;
        if1.loop = 1'b1;
        @(negedge clk);
        base = cyc;
        push_ev(base + 2,   1'b0, DIV_A,  1'b1, -1);
        push_ev(base + 43,  1'b0, DIV_A,  1'b0, 38);
        push_ev(base + 64,  1'b0, DIV_C5, 1'b1, 0);
        push_ev(base + 76,  1'b0, DIV_A,  1'b1, 8);
        push_ev(base + 117, 1'b0, DIV_A,  1'b0, 38);
        push_ev(base + 138, 1'b0, DIV_C5, 1'b1, 0);
        push_ev(base + 150, 1'b0, DIV_A,  1'b1, 8);
        if1.en = 1'b1;
        wait_until(base + 160);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL loop_missing: got %0d pending want 0", sb.size()); sb.delete(); end
        if1.en = 1'b0;
        if1.loop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_en_drop();
        int base;
        @(negedge clk);
        base = cyc;
        push_ev(base + 2, 1'b0, DIV_A, 1'b1, -1);
        if1.en = 1'b1;
        wait_until(base + 22);
        total++;
        if (if1.gate !== 1'b1) begin bad++; $display("FAIL drop_pre_gate: got %b want 1", if1.gate); end
        if1.en = 1'b0;
        @(negedge clk);
        total++;
        if (if1.gate !== 1'b0) begin bad++; $display("FAIL drop_gate: got %b want 0", if1.gate); end
        total++;
        if (if1.div !== DIV_A) begin bad++; $display("FAIL drop_div: got %0d want %0d", if1.div, DIV_A); end
        repeat (5) @(negedge clk);
        base = cyc;
        push_ev(base + 2, 1'b0, DIV_A, 1'b1, -1);
        if1.en = 1'b1;
        wait_until(base + 10);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL drop_missing: got %0d pending want 0", sb.size()); sb.delete(); end
        if1.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        int rel;
        @(negedge clk);
        base = cyc;
        push_ev(base + 2,  1'b0, DIV_A, 1'b1, -1);
        push_ev(base + 43, 1'b0, DIV_A, 1'b0, 38);
        if1.en = 1'b1;
        wait_until(base + 47);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (if1.div !== 15'd0) begin bad++; $display("FAIL async_div: got %0d want 0", if1.div); end
        total++;
        if (if1.gate !== 1'b0) begin bad++; $display("FAIL async_gate: got %b want 0", if1.gate); end
        total++;
        if (if1.note_stb !== 1'b0 || if1.done !== 1'b0) begin
            bad++; $display("FAIL async_strobes: got stb=%b done=%b want 0 0", if1.note_stb, if1.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        push_ev(rel + 2, 1'b0, DIV_A, 1'b1, -1);
        wait_until(rel + 6);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL restart_missing: got %0d pending want 0", sb.size()); sb.delete(); end
        if1.en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_oct_div();
        int base;
        sel = 1'b1;
        if2.loop = 1'b0;
        @(negedge clk);
        base = cyc;
        push_ev(base + 2,  1'b0, 15'd18181, 1'b1, -1);
        push_ev(base + 13, 1'b0, 15'd9090,  1'b1, 8);
        push_ev(base + 24, 1'b0, 15'd4544,  1'b1, 8);
        push_ev(base + 35, 1'b0, 15'd2271,  1'b1, 8);
        push_ev(base + 46, 1'b1, 15'd2271,  1'b0, 8);
        if2.en = 1'b1;
        wait_until(base + 55);
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL oct_missing: got %0d pending want 0", sb.size()); sb.delete(); end
        if2.en = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop();
        test_en_drop();
        test_reset_mid();
        test_oct_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
